minsoc_pic_wb: RTL and testbench

//  Parametrised programmable interrupt controller. Sits between SoC peripheral IRQ lines and the
//  CPU interrupt input. Adds per-channel level/rising-edge mode, input synchronisers, W1C status,
//  a priority vector register and a 32-bit Wishbone B3 classic slave for register access.

---
 rtl/minsoc_pic_wb.sv | 72 +++++++
 tb/tb_minsoc_pic_wb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/minsoc_pic_wb.sv
// minsoc_pic_wb: programmable interrupt controller with a Wishbone B3 classic register slave
module minsoc_pic_wb #(
  parameter int NINTS       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NINTS-1:0] irq_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             int_o
);
  logic [SYNC_STAGES-1:0][NINTS-1:0] sync_q, sync_d;
  logic [NINTS-1:0] prev_q, mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, s, mp, w1c;
  logic [31:0] dat_q, dat_d, vec;
  logic ack_q, ack_d, int_q, int_d, wr;
  logic [1:0] sel;
  logic [4:0] idx;
  logic unused_ok;
  // Bus decode, read mux (pre-commit values), priority encode and next register state
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    sel = wb_adr_i[3:2];
    ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
    wr = ack_d & wb_we_i;
    mp = pend_q & mask_q;
    idx = '0;
    for (int i = NINTS - 1; i >= 0; i--) idx = mp[i] ? 5'(i) : idx;
    vec = {|mp, 26'd0, idx};
    dat_d = !ack_d ? '0 : sel == 2'd0 ? 32'(mask_q) : sel == 2'd1 ? 32'(mode_q) : sel == 2'd2 ? 32'(pend_q) : vec;
    w1c = (wr && sel == 2'd2) ? wb_dat_i[NINTS-1:0] & mode_q : '0;
    mask_d = (wr && sel == 2'd0) ? wb_dat_i[NINTS-1:0] : mask_q;
    mode_d = (wr && sel == 2'd1) ? wb_dat_i[NINTS-1:0] : mode_q;
    pend_d = (mode_q & ((s & ~prev_q) | (pend_q & ~w1c))) | (~mode_q & s);
    int_d = |mp;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
      dat_q  <= '0;
      ack_q  <= 1'b0;
      int_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= s;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      dat_q  <= dat_d;
      ack_q  <= ack_d;
      int_q  <= int_d;
    end
  end
  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign int_o     = int_q;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
endmodule

// File: tb/tb_minsoc_pic_wb.sv
// tb_minsoc_pic_wb: scoreboard bench with a behavioural PIC model, directed and random stimulus
module tb_minsoc_pic_wb;
  localparam int N  = 20;
  localparam int SS = 2;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] irq20 = '0;
  logic [31:0] irq32 = '0;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] adr = '0, sel = '0;
  logic [31:0] dat = '0;
  logic [31:0] dat_o, dat32;
  logic ack, ack32, err, err32, int_o, int32;
  int checks = 0, failures = 0;
  bit mon_en = 0;
  logic [31:0] exp_q[$];
  logic [N-1:0] hist[$];
  logic [N-1:0] m_mask, m_mode, m_pend, m_s, m_p, m_w1c, m_mp;
  logic m_ack = 0, m_int = 0, m_acc;
  logic [31:0] m_rd;
  logic [4:0] m_lo;
  bit m_found;

  always #5 clk = ~clk;

  minsoc_pic_wb #(.NINTS(N), .SYNC_STAGES(SS)) u20 (
    .clk_i(clk), .rst_n_i(rst_n), .irq_i(irq20), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .int_o(int_o));

  minsoc_pic_wb #(.NINTS(32), .SYNC_STAGES(SS)) u32 (
    .clk_i(clk), .rst_n_i(rst_n), .irq_i(irq32), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat32), .wb_ack_o(ack32),
    .wb_err_o(err32), .int_o(int32));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: s is the irq sample SS edges old, prev one edge older than s
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_ack = 0; m_int = 0;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back('0);
      exp_q.delete();
    end else begin
      m_s = hist[SS-1];
      m_p = hist[SS];
      m_acc = cyc && stb && !m_ack;
      m_mp = m_pend & m_mask;
      m_lo = '0; m_found = 0;
      for (int i = 0; i < N; i++) if (m_mp[i] && !m_found) begin m_lo = 5'(i); m_found = 1; end
      case (adr[3:2])
        2'd0: m_rd = 32'(m_mask);
        2'd1: m_rd = 32'(m_mode);
        2'd2: m_rd = 32'(m_pend);
        default: m_rd = {m_found, 26'd0, m_lo};
      endcase
      m_w1c = (m_acc && we && adr[3:2] == 2'd2) ? dat[N-1:0] & m_mode : '0;
      for (int n = 0; n < N; n++)
        m_pend[n] = m_mode[n] ? ((m_s[n] && !m_p[n]) || (m_pend[n] && !m_w1c[n])) : m_s[n];
      m_int = |m_mp;
      if (m_acc && we && adr[3:2] == 2'd0) m_mask = dat[N-1:0];
      if (m_acc && we && adr[3:2] == 2'd1) m_mode = dat[N-1:0];
      if (m_acc) exp_q.push_back(m_rd);
      m_ack = m_acc;
      hist.push_front(irq20);
      void'(hist.pop_back());
    end
  end

  // Monitor: pops expected read data whenever the DUT acks, tracks ack/int cycle by cycle
  always @(negedge clk) if (mon_en) begin
    chk("ack", 32'(ack), 32'(m_ack));
    chk("int", 32'(int_o), 32'(m_int));
    chk("err", 32'(err), 32'd0);
    if (ack) begin
      if (exp_q.size() == 0) chk("sb_empty_on_ack", 32'(exp_q.size()), 32'd1);
      else chk("rdata", dat_o, exp_q.pop_front());
    end else chk("idle_dat", dat_o, 32'd0);
  end

  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] r, output logic [31:0] r32);
    int n;
    n = 0;
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = 4'($urandom);
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    chk("ack_seen", 32'(ack), 32'd1);
    r = dat_o;
    r32 = dat32;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r, r32;
    logic [5:0] pat;
    tick(2);
    rst_n = 1; mon_en = 1;
    // reset with random state
    for (int i = 0; i < 3; i++) xfer(1, 4'(i * 4), $urandom, r, r32);
    irq20 = N'($urandom);
    tick(4);
    rst_n = 0; irq20 = '0; irq32 = '0;
    tick(1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_int", 32'(int_o), 32'd0);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin xfer(0, 4'(i * 4), 0, r, r32); chk("rst_reg", r, 32'd0); end
    // level latency
    xfer(1, 4'h4, 0, r, r32);
    xfer(1, 4'h0, 1, r, r32);
    irq20[0] = 1;
    tick(3); chk("lvl_rise_e3", 32'(int_o), 32'd0);
    tick(1); chk("lvl_rise_e4", 32'(int_o), 32'd1);
    irq20[0] = 0;
    tick(3); chk("lvl_fall_e3", 32'(int_o), 32'd1);
    tick(1); chk("lvl_fall_e4", 32'(int_o), 32'd0);
    // edge mode and W1C
    xfer(1, 4'h4, 32'h4, r, r32);
    xfer(1, 4'h0, 32'h4, r, r32);
    irq20[2] = 1; tick(1); irq20[2] = 0;
    tick(4);
    xfer(0, 4'h8, 0, r, r32); chk("edge_pend", r, 32'h4);
    xfer(0, 4'hC, 0, r, r32); chk("edge_vec", r, 32'h8000_0002);
    chk("edge_int", 32'(int_o), 32'd1);
    xfer(1, 4'h8, 32'h4, r, r32);
    xfer(0, 4'h8, 0, r, r32); chk("w1c_pend", r, 32'h0);
    chk("w1c_int", 32'(int_o), 32'd0);
    // collision: new edge lands on the W1C commit edge
    irq20[2] = 1; tick(1); irq20[2] = 0;
    tick(4);
    xfer(0, 4'h8, 0, r, r32); chk("edge_again", r, 32'h4);
    irq20[2] = 1; tick(2);
    xfer(1, 4'h8, 32'h4, r, r32);
    irq20[2] = 0;
    xfer(0, 4'h8, 0, r, r32); chk("collision_set_wins", r, 32'h4);
    xfer(1, 4'h8, 32'h4, r, r32);
    xfer(0, 4'h8, 0, r, r32); chk("w1c_after", r, 32'h0);
    // priority and mask
    xfer(1, 4'h4, 0, r, r32);
    irq20 = 20'h0000A;
    xfer(1, 4'h0, 32'h8, r, r32);
    tick(4);
    xfer(0, 4'h8, 0, r, r32); chk("lvl_pend", r, 32'hA);
    xfer(0, 4'hC, 0, r, r32); chk("prio_vec", r, 32'h8000_0003);
    chk("prio_int", 32'(int_o), 32'd1);
    xfer(1, 4'h8, 32'hA, r, r32);
    xfer(0, 4'h8, 0, r, r32); chk("lvl_w1c_ignored", r, 32'hA);
    xfer(1, 4'h0, 0, r, r32);
    tick(1); chk("mask_off_int", 32'(int_o), 32'd0);
    xfer(0, 4'hC, 0, r, r32); chk("mask_off_vec", r, 32'h0);
    irq20 = '0;
    // back-to-back strobes
    cyc = 1; stb = 1; we = 0; adr = 4'h0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); pat[i] = ack; tick(1); end
    cyc = 0; stb = 0;
    chk("ack_pattern", 32'(pat), 32'b101010);
    // 32-channel build, bit 31
    xfer(1, 4'h0, 32'h8000_0001, r, r32);
    xfer(0, 4'h0, 0, r, r32);
    chk("n20_mask_trunc", r, 32'h1);
    chk("n32_mask", r32, 32'h8000_0001);
    irq32[31] = 1;
    tick(4);
    xfer(0, 4'hC, 0, r, r32); chk("n32_vec", r32, 32'h8000_001F);
    chk("n32_int", 32'(int32), 32'd1);
    xfer(1, 4'h0, 0, r, r32);
    xfer(0, 4'h0, 0, r, r32); chk("n32_mask_clr", r32, 32'h0);
    chk("n32_int_clr", 32'(int32), 32'd0);
    irq32 = '0;
    // random traffic against the model
    repeat (300) begin
      if ($urandom_range(0, 2) == 0) irq20 = N'($urandom);
      xfer(1'($urandom_range(0, 1)), 4'($urandom), $urandom, r, r32);
      tick($urandom_range(0, 2));
    end
    tick(5);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
